puf_resp_scanner: RTL and testbench
===================================

# puf_resp_scanner

Parametrised successor to the team's fixed 16:1 response multiplexer. Selects one of `N_CH` arbiter-PUF response bits, either directly under an external select or through an internal scan sequencer. The scan sequencer waits a programmable settle time per channel, assembles all channels into a parallel word, and hands the word off with a valid/ready handshake. It sits between the arbiter-chain array and the response capture/UART logic.

## Interface
Parameters:
- `N_CH`, 16: number of response channels, 2..64; need not be a power of two.
- `SEL_W`, `$clog2(N_CH)`: select/index width.
- `SETTLE`, 2: idle cycles before each scan sample, 0..255.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in`, in, `N_CH`: PUF response bits; `in[k]` is channel k.
- `sel`, in, `SEL_W`: direct-mode channel select.
- `mode`, in, 1: 0 = direct, 1 = scan; sampled only when `start` is accepted.
- `start`, in, 1: scan request, one-cycle pulse or level.
- `out`, out, 1: registered selected bit.
- `busy`, out, 1: high in SCAN and HOLD.
- `word`, out, `N_CH`: assembled scan word; `word[k]` holds channel k.
- `word_valid`, out, 1: `word` complete and stable.
- `word_ready`, in, 1: consumer accepts `word`.

## Operation
- Reset values: `out`=0, `busy`=0, `word`=0, `word_valid`=0. Internal index and settle counter are 0, and the FSM is in IDLE.
- FSM states are IDLE, SCAN and HOLD.
- IDLE, direct behaviour: each cycle `out` <= `in[sel]`. If `sel` >= `N_CH`, `out` <= 0.
- IDLE, start handling: a start is accepted when `start`=1 and `mode`=1.
  - On accept: go to SCAN, index=0, settle counter=`SETTLE`, `word` <= 0.
  - `start`=1 with `mode`=0 has no effect.
- SCAN:
  - If settle counter != 0: decrement it; `out` holds its value.
  - Else (sample edge): `word[index]` <= `in[index]` and `out` <= `in[index]`.
    - If index = `N_CH`-1: go to HOLD and set `word_valid`=1.
    - Otherwise: index++ and settle counter = `SETTLE`.
- SCAN ignores `mode`, `sel` and `start`.
- HOLD:
  - `word` and `out` are frozen.
  - On an edge with `word_valid` & `word_ready`: `word_valid` <= 0 and go to IDLE. `word` keeps its last value until the next accepted start.
- `start` is ignored in HOLD and on the transfer edge. Back-to-back scans therefore have at least one IDLE cycle between them.
- Reset asserted mid-scan or in HOLD: all outputs return to reset values immediately (asynchronous). No partial word is presented after reset.
- The index never exceeds `N_CH`-1 and never wraps. Only channels 0..`N_CH`-1 are sampled, including when `N_CH` is not a power of two.

## Timing
- Direct mode latency is 1 cycle: a `sel`/`in` change before edge E appears on `out` after E.
- Start accepted on edge T:
  - Channel k is sampled on edge T + (k+1)·(`SETTLE`+1).
  - `word_valid` rises after edge T + `N_CH`·(`SETTLE`+1).
  - With defaults (16 channels, `SETTLE`=2), `word_valid` rises after edge T+48.
- `busy` rises after edge T and falls after the transfer edge.
- `word_ready` may be held high in advance. The transfer then occurs on the first edge where `word_valid`=1, so `word_valid` is high for exactly one cycle.
- `word_valid` never drops without a transfer, except on reset.
- No combinational path exists from any input to any output.

## Test plan
- Direct sweep, `N_CH`=16: `in`=16'hA5C3, `sel`=0..15 one per cycle → `out` matches `in[sel]` one cycle later. Repeat with `N_CH`=12 and `sel`=12..15 → `out`=0.
- Default scan: `in`=16'h1234 held, `start` pulse, `word_ready`=1 → `word_valid` rises 48 cycles after accept, `word`=16'h1234, valid lasts 1 cycle, `busy` high for 49 cycles.
- Channel timing, `SETTLE`=0: `in` toggles `in[k]` only on channel k's sample cycle → each bit is captured on its own sample edge, and `word_valid` rises 16 cycles after accept.
- Backpressure: `word_ready`=0 for 10 cycles after `word_valid` while `in` changes → `word`, `out` and `word_valid` stay stable. When `word_ready`=1 is applied, transfer happens on that edge, and a `start` on that same edge is ignored.
- Ignored inputs: `start` with `mode`=0 → stays IDLE, `busy`=0. During SCAN, toggle `mode`, `sel` and `start` → scan result and timing are unchanged.
- Reset mid-operation: assert `rst_n`=0 at channel 7 of a scan and in HOLD → all outputs go to 0 without waiting for a clock. After release, a fresh start produces a full correct word.

Source files
------------

// File: rtl/puf_resp_scanner.sv
// puf_resp_scanner
//   Selects one of N_CH arbiter-PUF response bits. In IDLE the bit picked
//   by `sel` is registered onto `out` every cycle. A start with mode=1
//   launches a scan: each channel is sampled in order after SETTLE idle
//   cycles, the bits are collected into `word`, and the finished word is
//   handed off with a word_valid/word_ready handshake.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   in[N_CH]     : response bits, in[k] is channel k
//   sel[SEL_W]   : direct-mode channel select (out of range gives 0)
//   mode, start  : scan request, accepted in IDLE when both are high
//   out          : registered selected / last sampled bit
//   busy         : high while scanning or holding a finished word
//   word[N_CH]   : assembled scan word, word[k] is channel k
//   word_valid   : word complete and stable
//   word_ready   : consumer accepts word
module puf_resp_scanner #(
    parameter int N_CH   = 16,
    parameter int SEL_W  = $clog2(N_CH),
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic              start,
    output logic              out,
    output logic              busy,
    output logic [N_CH-1:0]   word,
    output logic              word_valid,
    input  logic              word_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);
    localparam logic [SEL_W:0]   N_CH_L   = (SEL_W + 1)'(N_CH);
    localparam logic [7:0]       SETTLE_L = 8'(SETTLE);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              out_q, out_d;
    logic [N_CH-1:0]   word_q, word_d;
    logic              valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        word_d  = word_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                // Non-power-of-two channel counts leave select codes with
                // no channel behind them; those read as 0.
                out_d = ({1'b0, sel} < N_CH_L) ? in[sel] : 1'b0;
                if (start && mode) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    cnt_d   = SETTLE_L;
                    word_d  = '0;
                end
            end
            SCAN: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    word_d[idx_q] = in[idx_q];
                    out_d         = in[idx_q];
                    if (idx_q == LAST_IDX) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                        cnt_d = SETTLE_L;
                    end
                end
            end
            HOLD: begin
                // start is deliberately not looked at here, so the
                // transfer edge always lands in IDLE first.
                if (valid_q && word_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign out        = out_q;
    assign busy       = (state_q != IDLE);
    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: tb/tb_puf_resp_scanner.sv
// Bench for puf_resp_scanner: a default instance (16 channels, settle 2)
// and a 12-channel, settle-0 instance, driven with random response bits.
module tb_puf_resp_scanner;

    localparam int NA = 16;
    localparam int SA = 2;
    localparam int NB = 12;

    logic clk;
    logic rst_n;

    logic [NA-1:0] in_a;
    logic [3:0]    sel_a;
    logic          mode_a, start_a, ready_a;
    logic          out_a, busy_a, valid_a;
    logic [NA-1:0] word_a;

    logic [NB-1:0] in_b;
    logic [3:0]    sel_b;
    logic          mode_b, start_b, ready_b;
    logic          out_b, busy_b, valid_b;
    logic [NB-1:0] word_b;

    int n_cmp = 0;
    int n_bad = 0;

    puf_resp_scanner #(.N_CH(NA), .SETTLE(SA)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in_a),
        .sel        (sel_a),
        .mode       (mode_a),
        .start      (start_a),
        .out        (out_a),
        .busy       (busy_a),
        .word       (word_a),
        .word_valid (valid_a),
        .word_ready (ready_a)
    );

    puf_resp_scanner #(.N_CH(NB), .SETTLE(0)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in_b),
        .sel        (sel_b),
        .mode       (mode_b),
        .start      (start_b),
        .out        (out_b),
        .busy       (busy_b),
        .word       (word_b),
        .word_valid (valid_b),
        .word_ready (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_out"},  out_a,   0);
        check({tag, "_busy"}, busy_a,  0);
        check({tag, "_word"}, word_a,  0);
        check({tag, "_vld"},  valid_a, 0);
    endtask

    // One full scan on instance A. The expected word is the value each
    // channel's input had on its own sample edge, T + (k+1)*(SA+1).
    task automatic scan_a(input bit noise, input bit ready_early, input bit rst_in_hold);
        logic [NA-1:0] exp;
        logic          prev;
        exp     = '0;
        ready_a = ready_early;
        mode_a  = 1'b1;
        start_a = 1'b1;
        step();
        prev    = in_a[sel_a];
        start_a = 1'b0;
        mode_a  = 1'b0;
        check("acc_busy", busy_a, 1);
        check("acc_word", word_a, 0);
        check("acc_vld",  valid_a, 0);
        check("acc_out",  out_a, prev);
        for (int k = 0; k < NA; k++) begin
            for (int s = 0; s <= SA; s++) begin
                in_a = NA'($urandom);
                if (noise) begin
                    mode_a  = 1'($urandom);
                    sel_a   = 4'($urandom);
                    start_a = 1'($urandom);
                end
                step();
                if (s == SA) begin
                    exp[k] = in_a[k];
                    prev   = in_a[k];
                    check("sample_out", out_a, prev);
                end else begin
                    check("settle_out", out_a, prev);
                end
                check("scan_busy", busy_a, 1);
                if (!(k == NA - 1 && s == SA))
                    check("scan_vld", valid_a, 0);
            end
        end
        start_a = 1'b0;
        mode_a  = 1'b0;
        check("done_vld",  valid_a, 1);
        check("done_word", word_a, exp);
        if (rst_in_hold) begin
            #2 rst_n = 1'b0;
            #1 check_a_zero("hold_rst");
            step();
            check_a_zero("hold_rst2");
            rst_n = 1'b1;
            return;
        end
        if (!ready_early) begin
            for (int i = 0; i < 10; i++) begin
                in_a = NA'($urandom);
                step();
                check("bp_vld",  valid_a, 1);
                check("bp_word", word_a, exp);
                check("bp_out",  out_a, prev);
                check("bp_busy", busy_a, 1);
            end
            ready_a = 1'b1;
            start_a = 1'b1;
            mode_a  = 1'b1;
        end
        step();
        check("xfer_vld",  valid_a, 0);
        check("xfer_busy", busy_a, 0);
        check("xfer_word", word_a, exp);
        check("xfer_out",  out_a, prev);
        start_a = 1'b0;
        mode_a  = 1'b0;
        step();
        check("post_busy", busy_a, 0);
        check("post_vld",  valid_a, 0);
        check("post_word", word_a, exp);
        ready_a = 1'b0;
    endtask

    initial begin
        logic [NB-1:0] expb;
        rst_n = 1'b0;
        in_a = '0; sel_a = '0; mode_a = 0; start_a = 0; ready_a = 0;
        in_b = '0; sel_b = '0; mode_b = 0; start_b = 0; ready_b = 0;
        #12;
        check_a_zero("rst");
        check("rst_b_out",  out_b, 0);
        check("rst_b_busy", busy_b, 0);
        check("rst_b_word", word_b, 0);
        check("rst_b_vld",  valid_b, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Direct mode, fixed pattern then random
        in_a = 16'hA5C3;
        for (int i = 0; i < NA; i++) begin
            sel_a = 4'(i);
            step();
            check("dir_a5c3", out_a, in_a[i]);
        end
        for (int i = 0; i < 20; i++) begin
            in_a  = NA'($urandom);
            sel_a = 4'($urandom);
            step();
            check("dir_rand", out_a, in_a[sel_a]);
        end

        // Direct mode on 12 channels, including unmapped selects
        for (int i = 0; i < 16; i++) begin
            in_b  = NB'($urandom);
            sel_b = 4'(i);
            step();
            check("dir_b", out_b, (i < NB) ? in_b[i] : 1'b0);
        end

        // start with mode=0 does nothing
        start_a = 1'b1;
        mode_a  = 1'b0;
        in_a    = NA'($urandom);
        step();
        check("nomode_busy", busy_a, 0);
        check("nomode_out",  out_a, in_a[sel_a]);
        step();
        check("nomode_busy2", busy_a, 0);
        start_a = 1'b0;

        scan_a(0, 1, 0);
        scan_a(0, 0, 0);
        scan_a(1, 1, 0);
        scan_a(1, 0, 0);

        // Reset while channel 7 is settling
        in_a    = '1;
        sel_a   = '0;
        mode_a  = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        mode_a  = 1'b0;
        repeat (7 * (SA + 1) + 1) step();
        check("mid_busy", busy_a, 1);
        check("mid_out",  out_a, 1);
        check("mid_word", word_a, 16'h007F);
        #2 rst_n = 1'b0;
        #1 check_a_zero("mid_rst");
        step();
        rst_n = 1'b1;
        scan_a(0, 1, 0);

        // Reset while holding a finished word, then a clean scan
        scan_a(0, 0, 1);
        scan_a(0, 1, 0);

        // 12 channels, no settle: channel k sampled k+1 edges after accept
        expb    = '0;
        ready_b = 1'b1;
        mode_b  = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        mode_b  = 1'b0;
        check("b_acc_busy", busy_b, 1);
        check("b_acc_word", word_b, 0);
        for (int k = 0; k < NB; k++) begin
            in_b = NB'($urandom);
            step();
            expb[k] = in_b[k];
            check("b_sample_out", out_b, in_b[k]);
            check("b_vld", valid_b, (k == NB - 1) ? 1'b1 : 1'b0);
        end
        check("b_word", word_b, expb);
        step();
        check("b_xfer_vld",  valid_b, 0);
        check("b_xfer_busy", busy_b, 0);
        check("b_xfer_word", word_b, expb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
